// File: rtl/calc_arb_pkg.sv
// Shared types and constants for the two-requester arbiter around the calc add/subtract unit.
package calc_arb_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;

endpackage

// File: rtl/calc_arbiter_if.sv
// Handshake and operand bus between the two front-ends (master) and the arbiter (slave).
interface calc_arbiter_if;
  import calc_arb_pkg::*;

  logic             req0, sel0, ack0, gnt0, done0;
  logic [WIDTH-1:0] a0, b0;
  logic             req1, sel1, ack1, gnt1, done1;
  logic [WIDTH-1:0] a1, b1;
  logic [WIDTH-1:0] res;
  logic             res_zero;

  modport slave (
    input  req0, sel0, a0, b0, ack0,
    input  req1, sel1, a1, b1, ack1,
    output gnt0, done0, gnt1, done1, res, res_zero
  );

  modport master (
    output req0, sel0, a0, b0, ack0,
    output req1, sel1, a1, b1, ack1,
    input  gnt0, done0, gnt1, done1, res, res_zero
  );

endinterface

// File: rtl/calc.sv
// Shared 16-bit add/subtract datapath: o_z = i_x + i_y, or i_x - i_y when i_sel is set.
module calc
  import calc_arb_pkg::*;
(
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_z
);

  logic [WIDTH-1:0] w_y_eff;

  // Subtraction as x + (~y + 1); the sum wraps modulo 2^WIDTH.
  assign w_y_eff = i_sel ? (~i_y + {{(WIDTH-1){1'b0}}, 1'b1}) : i_y;
  assign o_z     = i_x + w_y_eff;

endmodule

// File: rtl/calc_rr_pick.sv
// Combinational winner select between two requesters, round-robin or fixed priority.
module calc_rr_pick #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_id,
  output logic o_valid,
  output logic o_id
);
  import calc_arb_pkg::*;

  logic w_tie_id;

  // On a tie, round-robin hands the grant to whoever did not win last.
  assign w_tie_id = PRIO_FIXED ? ID0 : ~i_last_id;
  assign o_valid  = i_req0 | i_req1;
  assign o_id     = (i_req0 & i_req1) ? w_tie_id : (i_req1 ? ID1 : ID0);

endmodule

// File: rtl/calc_arbiter.sv
// Arbitrates two requesters onto one calc unit; holds each result until its owner acknowledges.
module calc_arbiter #(
  parameter int WIDTH      = 16,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  calc_arbiter_if.slave        bus
);
  import calc_arb_pkg::*;

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a, r_op_b;
  logic             r_op_sel;
  logic             r_owner;
  logic             r_last_id;
  logic             r_gnt0, r_gnt1, r_done0, r_done1;
  logic [WIDTH-1:0] r_res;
  logic             r_res_zero;

  logic             w_valid, w_id, w_owner_ack;
  logic [WIDTH-1:0] w_z;

  calc_rr_pick #(.PRIO_FIXED(PRIO_FIXED)) u_pick (
    .i_req0    (bus.req0),
    .i_req1    (bus.req1),
    .i_last_id (r_last_id),
    .o_valid   (w_valid),
    .o_id      (w_id)
  );

  calc u_calc (
    .i_x   (r_op_a),
    .i_y   (r_op_b),
    .i_sel (r_op_sel),
    .o_z   (w_z)
  );

  // Only the current owner's ack releases DONE.
  assign w_owner_ack = (r_owner == ID1) ? bus.ack1 : bus.ack0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_res      <= '0;
      r_res_zero <= 1'b0;
      r_last_id  <= ID1;
      r_owner    <= ID0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_op_a    <= (w_id == ID1) ? bus.a1   : bus.a0;
            r_op_b    <= (w_id == ID1) ? bus.b1   : bus.b0;
            r_op_sel  <= (w_id == ID1) ? bus.sel1 : bus.sel0;
            r_owner   <= w_id;
            r_last_id <= w_id;
            r_gnt0    <= (w_id == ID0);
            r_gnt1    <= (w_id == ID1);
            r_state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res      <= w_z;
          r_res_zero <= (w_z == '0);
          r_done0    <= (r_owner == ID0);
          r_done1    <= (r_owner == ID1);
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          if (w_owner_ack) begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt0     = r_gnt0;
  assign bus.gnt1     = r_gnt1;
  assign bus.done0    = r_done0;
  assign bus.done1    = r_done1;
  assign bus.res      = r_res;
  assign bus.res_zero = r_res_zero;

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter: round-robin instance (ifa) and fixed-priority instance (ifb).
module tb_calc_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  calc_arbiter_if ifa ();
  calc_arbiter_if ifb ();

  calc_arbiter #(.WIDTH(16), .PRIO_FIXED(1'b0)) u_dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  calc_arbiter #(.WIDTH(16), .PRIO_FIXED(1'b1)) u_dut_fx (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    {ifa.req0, ifa.sel0, ifa.ack0, ifa.req1, ifa.sel1, ifa.ack1} = '0;
    {ifa.a0, ifa.b0, ifa.a1, ifa.b1} = '0;
    {ifb.req0, ifb.sel0, ifb.ack0, ifb.req1, ifb.sel1, ifb.ack1} = '0;
    {ifb.a0, ifb.b0, ifb.a1, ifb.b1} = '0;

    // Reset state
    tick();
    tick();
    chk1("rst_gnt0", ifa.gnt0, 1'b0);
    chk1("rst_gnt1", ifa.gnt1, 1'b0);
    chk1("rst_done0", ifa.done0, 1'b0);
    chk1("rst_done1", ifa.done1, 1'b0);
    chk16("rst_res", ifa.res, 16'h0000);
    chk1("rst_zero", ifa.res_zero, 1'b0);
    rst = 1'b0;

    // Requester 0 add, with operands disturbed after the grant
    ifa.req0 = 1'b1; ifa.sel0 = 1'b0; ifa.a0 = 16'h1234; ifa.b0 = 16'h0001;
    tick();
    chk1("add_gnt0", ifa.gnt0, 1'b1);
    chk1("add_gnt1", ifa.gnt1, 1'b0);
    chk1("add_done0_early", ifa.done0, 1'b0);
    ifa.req0 = 1'b0; ifa.a0 = 16'hFFFF; ifa.b0 = 16'hFFFF; ifa.sel0 = 1'b1;
    tick();
    chk1("add_gnt0_pulse", ifa.gnt0, 1'b0);
    chk1("add_done0", ifa.done0, 1'b1);
    chk16("add_res", ifa.res, 16'h1235);
    chk1("add_zero", ifa.res_zero, 1'b0);
    tick();
    chk1("add_done0_hold", ifa.done0, 1'b1);
    chk16("add_res_hold", ifa.res, 16'h1235);
    ifa.ack0 = 1'b1;
    tick();
    ifa.ack0 = 1'b0;
    chk1("add_done0_ack", ifa.done0, 1'b0);

    // Requester 1 subtract to negative; foreign ack ignored
    ifa.req1 = 1'b1; ifa.sel1 = 1'b1; ifa.a1 = 16'd5; ifa.b1 = 16'd7;
    tick();
    chk1("sub_gnt1", ifa.gnt1, 1'b1);
    chk1("sub_gnt0", ifa.gnt0, 1'b0);
    ifa.req1 = 1'b0;
    tick();
    chk1("sub_done1", ifa.done1, 1'b1);
    chk1("sub_done0", ifa.done0, 1'b0);
    chk16("sub_res", ifa.res, 16'hFFFE);
    chk1("sub_zero", ifa.res_zero, 1'b0);
    ifa.ack0 = 1'b1;
    tick();
    ifa.ack0 = 1'b0;
    chk1("sub_foreign_ack", ifa.done1, 1'b1);
    chk16("sub_res_hold", ifa.res, 16'hFFFE);
    ifa.ack1 = 1'b1;
    tick();
    ifa.ack1 = 1'b0;
    chk1("sub_done1_ack", ifa.done1, 1'b0);

    // Subtract to zero
    ifa.req1 = 1'b1; ifa.sel1 = 1'b1; ifa.a1 = 16'd9; ifa.b1 = 16'd9;
    tick();
    ifa.req1 = 1'b0;
    tick();
    chk1("zero_done1", ifa.done1, 1'b1);
    chk16("zero_res", ifa.res, 16'h0000);
    chk1("zero_flag", ifa.res_zero, 1'b1);
    ifa.ack1 = 1'b1;
    tick();
    ifa.ack1 = 1'b0;

    // Add wrap-around
    ifa.req0 = 1'b1; ifa.sel0 = 1'b0; ifa.a0 = 16'hFFFF; ifa.b0 = 16'h0002;
    tick();
    chk1("wrap_gnt0", ifa.gnt0, 1'b1);
    ifa.req0 = 1'b0;
    tick();
    chk16("wrap_res", ifa.res, 16'h0001);
    chk1("wrap_zero", ifa.res_zero, 1'b0);
    chk1("wrap_done0", ifa.done0, 1'b1);
    ifa.ack0 = 1'b1;
    tick();
    ifa.ack0 = 1'b0;

    // Round-robin from a fresh reset: both held, acks held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifa.a0 = 16'd100; ifa.b0 = 16'd1; ifa.sel0 = 1'b0;
    ifa.a1 = 16'd200; ifa.b1 = 16'd1; ifa.sel1 = 1'b1;
    ifa.req0 = 1'b1; ifa.req1 = 1'b1; ifa.ack0 = 1'b1; ifa.ack1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1($sformatf("rr_gnt0_%0d", k), ifa.gnt0, (k % 2) == 0);
      chk1($sformatf("rr_gnt1_%0d", k), ifa.gnt1, (k % 2) == 1);
      tick();
      chk1($sformatf("rr_done0_%0d", k), ifa.done0, (k % 2) == 0);
      chk16($sformatf("rr_res_%0d", k), ifa.res, ((k % 2) == 0) ? 16'd101 : 16'd199);
      tick();
    end
    ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.ack0 = 1'b0; ifa.ack1 = 1'b0;
    tick();
    chk1("rr_idle_gnt0", ifa.gnt0, 1'b0);
    chk1("rr_idle_gnt1", ifa.gnt1, 1'b0);

    // Reset in DONE abandons the op; a pending req0 is granted afterwards
    ifa.req1 = 1'b1; ifa.sel1 = 1'b0; ifa.a1 = 16'd3; ifa.b1 = 16'd4;
    tick();
    chk1("rd_gnt1", ifa.gnt1, 1'b1);
    ifa.req1 = 1'b0;
    tick();
    chk1("rd_done1", ifa.done1, 1'b1);
    chk16("rd_res", ifa.res, 16'd7);
    ifa.req0 = 1'b1; ifa.sel0 = 1'b0; ifa.a0 = 16'd10; ifa.b0 = 16'd20;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("rd_done1_rst", ifa.done1, 1'b0);
    chk16("rd_res_rst", ifa.res, 16'h0000);
    chk1("rd_gnt0_rst", ifa.gnt0, 1'b0);
    tick();
    chk1("rd_gnt0_after", ifa.gnt0, 1'b1);
    ifa.req0 = 1'b0;
    tick();
    chk1("rd_done0", ifa.done0, 1'b1);
    chk16("rd_res0", ifa.res, 16'd30);
    ifa.ack0 = 1'b1;
    tick();
    ifa.ack0 = 1'b0;
    chk1("rd_done0_ack", ifa.done0, 1'b0);

    // Fixed priority: requester 0 always wins while it keeps requesting
    ifb.a0 = 16'd100; ifb.b0 = 16'd1; ifb.sel0 = 1'b0;
    ifb.a1 = 16'd50;  ifb.b1 = 16'd8; ifb.sel1 = 1'b1;
    ifb.req0 = 1'b1; ifb.req1 = 1'b1; ifb.ack0 = 1'b1; ifb.ack1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1($sformatf("fx_gnt0_%0d", k), ifb.gnt0, 1'b1);
      chk1($sformatf("fx_gnt1_%0d", k), ifb.gnt1, 1'b0);
      tick();
      chk16($sformatf("fx_res_%0d", k), ifb.res, 16'd101);
      tick();
    end
    ifb.req0 = 1'b0;
    tick();
    chk1("fx_gnt1_last", ifb.gnt1, 1'b1);
    chk1("fx_gnt0_last", ifb.gnt0, 1'b0);
    ifb.req1 = 1'b0;
    tick();
    chk1("fx_done1", ifb.done1, 1'b1);
    chk16("fx_res1", ifb.res, 16'd42);
    ifb.ack0 = 1'b0; ifb.ack1 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
- Shares one 16-bit add/subtract unit (the existing `calc` block: Z = X + Y, or X − Y when SEL=1) between two requesters.
- Arbitrates requests and latches the winner's operands and op into registers that drive the calc instance.
- Registers the result and holds it, with a zero flag, until the owning requester acknowledges.
- Sits between the two operand-producing front-ends and the shared arithmetic datapath.

Parameters:
- WIDTH, 16: operand/result width; fixed at 16 to match the calc datapath (other values unsupported).
- PRIO_FIXED, 0: 0 = round-robin between requesters; 1 = requester 0 always wins ties.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 operation request; held until gnt0
- sel0  input  1  requester 0 op: 0 = add, 1 = subtract
- a0  input  16  requester 0 operand X
- b0  input  16  requester 0 operand Y
- gnt0  output  1  one-cycle pulse: requester 0 operands captured
- done0  output  1  result for requester 0 valid, held until ack0
- ack0  input  1  requester 0 consumes result
- req1, sel1, a1, b1, gnt1, done1, ack1: same definitions for requester 1
- res  output  16  registered result of the current owner's op
- res_zero  output  1  res == 0, valid while done0/done1 is high

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - state=IDLE; gnt0=gnt1=done0=done1=0; res=0; res_zero=0.
  - last_id=1, so requester 0 wins the first tie.
  - Reset mid-EXEC or mid-DONE abandons the op; no done pulse is produced.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If req0|req1 at an edge: pick a winner, latch op_a/op_b/op_sel/owner from the winner, pulse gnt<owner>=1 for exactly the next cycle, and go to EXEC.
  - If neither request is high, stay in IDLE.
- Winner pick:
  - Only one request high: that requester.
  - Both high with PRIO_FIXED=0: the requester ≠ last_id.
  - Both high with PRIO_FIXED=1: requester 0.
  - last_id := owner at grant.
- EXEC (one cycle):
  - calc computes combinationally from the latched operands.
  - At the edge: res := Z, res_zero := (Z==0), done<owner> := 1, go to DONE.
- DONE:
  - res, res_zero and done<owner> are held stable.
  - ack<owner> high at an edge: done<owner> := 0, go to IDLE.
  - ack from the non-owner, or any ack outside DONE, is ignored.
- Latency:
  - req sampled at edge E0 → gnt high in cycle E0+1 (EXEC) → done high from E0+2.
  - If ack is high in the first DONE cycle, the arbiter is back in IDLE at E0+3, giving a minimum of 3 cycles per op.
  - A new request cannot be accepted in the same edge as an ack.
- Arithmetic:
  - Results are modulo 2^16.
  - Subtract is a + (2^16 − b) truncated, i.e. a − b in two's complement.
  - No carry/overflow output.
- Requests arriving during EXEC/DONE wait; a losing request stays pending and is granted on the next IDLE.
- Requesters must hold sel/a/b from req assertion until gnt. Operand changes after gnt do not affect res.
- gnt0 and gnt1 are never high together; done0 and done1 are never high together.

Decomposition:
- Package `calc_arb_pkg`:
  - state encoding constants ST_IDLE/ST_EXEC/ST_DONE (2-bit)
  - WIDTH constant 16
  - requester id constants ID0=0, ID1=1
- Sub-module `calc_rr_pick`: combinational winner select (req0, req1, last_id, PRIO_FIXED → valid, id).
- Top level: FSM, operand/result registers, and one `calc` instance.

Test Plan:
- Reset, then req0=1, sel0=0, a0=16'h1234, b0=16'h0001 → gnt0 pulse 1 cycle after the sampling edge; one cycle later done0=1, res=16'h1235, res_zero=0; held until ack0; done0=0 the cycle after ack0.
- Requester 1: sel1=1, a1=5, b1=7 → res=16'hFFFE. Then a1=9, b1=9, sel1=1 → res=0, res_zero=1.
- Wrap: sel0=0, a0=16'hFFFF, b0=16'h0002 → res=16'h0001, no other flag.
- Round-robin (PRIO_FIXED=0): req0 and req1 held high continuously with immediate acks → grants alternate 0,1,0,1; first grant goes to 0 after reset.
- PRIO_FIXED=1 with both requests held high → every grant goes to requester 0; requester 1 is granted only after req0 drops.
- Assert rst while in DONE with done1=1 → next cycle done1=0, res=0, state IDLE; a pending req0 is granted normally afterwards. ack0 pulsed while requester 1 owns DONE → no effect.
